data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the single-port Data_Memory (1024 x 32, asynchronous read, write on posedge clk when WE=1, RD forced to 0 while WE=1). Port 0 serves the core load/store unit and port 1 serves the program/debug loader. The block grants one requester at a time using round-robin priority. It drives the memory address, write data and write enable, captures read data, and returns a one-cycle acknowledge.

Parameters:
DEPTH, 1024, number of 32-bit memory words; addresses >= DEPTH are out of range.
AW, 32, width of the requester and memory address buses (word address).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
p0_req  input  1  port 0 access request; held high until p0_ack.
p0_we  input  1  port 0: 1=write, 0=read; stable while p0_req=1.
p0_addr  input  AW  port 0 word address.
p0_wdata  input  32  port 0 write data.
p0_ack  output  1  port 0 one-cycle completion pulse.
p0_rdata  output  32  port 0 read data; valid when p0_ack=1.
p0_err  output  1  port 0 out-of-range flag; valid when p0_ack=1.
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err  same as port 0, for port 1.
mem_a  output  AW  to Data_Memory A.
mem_wd  output  32  to Data_Memory WD.
mem_we  output  1  to Data_Memory WE.
mem_rd  input  32  from Data_Memory RD.
busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous) forces the following values: state=IDLE; mem_a=0, mem_wd=0, mem_we=0; all ack and err outputs 0; all rdata outputs 0; busy=0; round-robin pointer favours port 0. mem_we drops immediately when reset asserts, so an in-flight write is aborted if reset precedes the write edge.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - If exactly one req is high, grant that port.
  - If both reqs are high, grant the port not served last. After reset, port 0 wins the first tie.
  - On grant, register the winner's addr to mem_a and wdata to mem_wd. Register mem_we = winner_we AND (addr < DEPTH). Also register the range result and the winner id. Go to ACCESS.
- ACCESS (1 cycle):
  - mem_* outputs stay stable.
  - For a write, the memory commits on the rising edge that ends ACCESS.
  - For an in-range read, mem_rd is sampled on the rising edge that ends ACCESS into the winner's rdata register.
  - For an out-of-range access, mem_we stays 0 and rdata loads 0.
  - Go to DONE.
- DONE (1 cycle):
  - The winner's ack=1. Its err = out-of-range. Its rdata holds the read value; for writes, rdata is 0.
  - mem_we=0. The pointer updates so the other port gets priority.
  - Go to IDLE.
- Ack, err and rdata outputs:
  - ack and err are single-cycle pulses.
  - rdata holds its value until that port's next completion.
- Latency: req high in IDLE gives ack exactly 2 cycles later. Minimum issue interval is 3 cycles per access.
- A requester that keeps req high after ack is treated as a new request in the following IDLE cycle. A competing pending request wins that arbitration through the round-robin pointer, so no port starves.
- Requests are sampled only in IDLE. Changes to req, we, addr or wdata during ACCESS or DONE are ignored.
- Address comparison is unsigned over the full AW bits.
- Reset released mid-sequence always restarts in IDLE. No ack is issued for an aborted transaction.

Test Plan:
- Single write then read: p0 write addr 28 data 32'hDEADBEEF, then p0 read addr 28. Required: mem_we high for exactly one cycle; second p0_ack with p0_rdata=32'hDEADBEEF, p0_err=0; each ack 2 cycles after req.
- Simultaneous requests: p0 read addr 5 and p1 write addr 6 data 32'h11, both raised in the same cycle from reset. Required: p0 acked first, then p1; a following tie grants p0 (pointer alternates).
- Starvation check: p0_req held high continuously while p1 requests 4 reads. Required: acks alternate p0, p1, p0, p1 and every p1 read completes.
- Out of range: p1 write addr 1024 data 32'hFFFFFFFF, then read addr 1024. Required: mem_we never asserts; p1_err=1 on both acks; p1_rdata=0.
- Reset mid-write: assert rst=0 during ACCESS of p0 write addr 3 data 32'h55. Required: mem_we drops immediately; no ack; state IDLE; a later read of addr 3 returns the previous contents (0 if never written).
- Input changes ignored: change p0_addr from 10 to 20 during ACCESS of a read. Required: mem_a stays 10; p0_rdata equals the contents of word 10.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the Data_Memory side of the arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface data_mem_arbiter_if #(
    parameter int AW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata;
    logic          p0_ack;
    logic [31:0]   p0_rdata;
    logic          p0_err;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata;
    logic          p1_ack;
    logic [31:0]   p1_rdata;
    logic          p1_err;

    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic          mem_we;
    logic [31:0]   mem_rd;
    logic          busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ack, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_err,
        output mem_a, mem_wd, mem_we,
        input  mem_rd,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_err,
        input  mem_a, mem_wd, mem_we,
        output mem_rd,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter and IDLE/ACCESS/DONE sequencer in front of a
// single-port, asynchronous-read data memory.
module data_mem_arbiter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [AW-1:0] w_addr  [2];
    logic [31:0]   w_wdata [2];

    logic          w_grant;
    logic          w_gnt_id;
    logic          w_gnt_inrange;

    logic [AW-1:0] r_mem_a;
    logic [31:0]   r_mem_wd;
    logic          r_mem_we;
    logic          r_win;
    logic          r_we;
    logic          r_inrange;
    logic          r_ptr;

    assign w_req      = {bus.p1_req, bus.p0_req};
    assign w_we       = {bus.p1_we,  bus.p0_we};
    assign w_addr[0]  = bus.p0_addr;
    assign w_addr[1]  = bus.p1_addr;
    assign w_wdata[0] = bus.p0_wdata;
    assign w_wdata[1] = bus.p1_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_ptr names the port that wins a tie; a lone requester always wins.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gnt_id     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant      = 1'b1;
                    w_gnt_id     = (&w_req) ? r_ptr : w_req[1];
                    w_state_next = ACCESS;
                end
            end
            ACCESS:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_gnt_inrange = (w_addr[w_gnt_id] < AW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_a   <= '0;
            r_mem_wd  <= '0;
            r_mem_we  <= 1'b0;
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_inrange <= 1'b0;
            r_ptr     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_mem_a   <= w_addr[w_gnt_id];
                r_mem_wd  <= w_wdata[w_gnt_id];
                r_mem_we  <= w_we[w_gnt_id] & w_gnt_inrange;
                r_win     <= w_gnt_id;
                r_we      <= w_we[w_gnt_id];
                r_inrange <= w_gnt_inrange;
            end
            // The write commits on the edge leaving ACCESS, so WE covers ACCESS only.
            if (r_state == ACCESS) begin
                r_mem_we <= 1'b0;
            end
            if (r_state == DONE) begin
                r_ptr <= ~r_win;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PID = 1'(gi);
            logic        r_ack;
            logic        r_err;
            logic [31:0] r_rdata;
            logic        w_done_here;

            assign w_done_here = (r_state == ACCESS) && (r_win == PID);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_ack <= w_done_here;
                    r_err <= w_done_here & ~r_inrange;
                    if (w_done_here) begin
                        r_rdata <= (!r_we && r_inrange) ? bus.mem_rd : 32'h0;
                    end
                end
            end
        end
    endgenerate

    assign bus.p0_ack   = g_port[0].r_ack;
    assign bus.p0_err   = g_port[0].r_err;
    assign bus.p0_rdata = g_port[0].r_rdata;
    assign bus.p1_ack   = g_port[1].r_ack;
    assign bus.p1_err   = g_port[1].r_err;
    assign bus.p1_rdata = g_port[1].r_rdata;

    assign bus.mem_a  = r_mem_a;
    assign bus.mem_wd = r_mem_wd;
    assign bus.mem_we = r_mem_we;
    assign bus.busy   = (r_state != IDLE);

endmodule
